// File: rtl/adc_poller_pkg.sv
// Shared types and constants for the ADC PIO poller: FSM state encoding,
// default sample width and the PIO data register address.
package adc_poller_pkg;

    localparam int DATA_W_DEF = 16;
    localparam logic [1:0] ADDR_DATA = 2'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/adc_pio_poller_sync_fifo.sv
// Synchronous FIFO with registered storage, a zeroed head while empty and an
// occupancy count. Pop is ignored when empty; push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = empty ? '0 : mem[rd_ptr];
    assign level     = count;

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
            else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adc_pio_poller.sv
// Avalon-MM initiator that polls the ADC PIO once per sample period
// (write command, read sample) and streams captured samples out of a FIFO.
module adc_pio_poller
    import adc_poller_pkg::*;
#(
    parameter int SAMPLE_DIV = 1024,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [15:0]                   cmd_word,
    input  logic                          clear_ovf,
    output logic [1:0]                    avm_address,
    output logic                          avm_chipselect,
    output logic                          avm_write_n,
    output logic [31:0]                   avm_writedata,
    input  logic [31:0]                   avm_readdata,
    output logic [DATA_W-1:0]             sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output state_e                        state
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    state_e           state_q;
    state_e           state_d;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             drop;
    logic             unused_rd_bits;

    assign unused_rd_bits = ^avm_readdata[31:DATA_W];

    assign tick = enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || !enable) div_cnt <= '0;
        else if (tick)        div_cnt <= '0;
        else                  div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A started sequence always runs to CAPTURE; enable only gates new ticks.
    always_comb begin
        state_d        = state_q;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = ADDR_DATA;
        avm_writedata  = '0;
        push           = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) state_d = WRITE;
            end
            WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = {16'b0, cmd_word};
                state_d        = READ;
            end
            READ: begin
                avm_chipselect = 1'b1;
                state_d        = CAPTURE;
            end
            CAPTURE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream handshake: sample_data is held stable while sample_valid is high
    // and the head is consumed on any clock edge where sample_valid && sample_ready.
    assign pop          = sample_valid && sample_ready;
    assign sample_valid = !fifo_empty;
    assign drop         = push && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (avm_readdata[DATA_W-1:0]),
        .pop       (pop),
        .head_data (sample_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fill_level)
    );

    // Set beats clear so a drop in the clear cycle is never lost.
    always_ff @(posedge clk) begin
        if (reset)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clear_ovf) overflow <= 1'b0;
    end

    assign state = state_q;

endmodule

// File: tb/tb_adc_pio_poller.sv
// Directed bench for adc_pio_poller with a registered PIO responder model
// and a queue-based scoreboard on the sample stream.
module tb_adc_pio_poller;
    import adc_poller_pkg::*;

    localparam int SAMPLE_DIV = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DATA_W     = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                enable;
    logic [15:0]         cmd_word;
    logic                clear_ovf;
    logic [1:0]          avm_address;
    logic                avm_chipselect;
    logic                avm_write_n;
    logic [31:0]         avm_writedata;
    logic [31:0]         avm_readdata = '0;
    logic [DATA_W-1:0]   sample_data;
    logic                sample_valid;
    logic                sample_ready;
    logic                overflow;
    logic [LVL_W-1:0]    fill_level;
    state_e              state;

    logic [15:0]         in_port;
    logic [DATA_W-1:0]   exp_q[$];
    logic [DATA_W-1:0]   mon_exp;
    int                  vectors = 0;
    int                  miscompares = 0;
    int                  cyc = 0;
    int                  bus_cnt = 0;
    int                  last_wr;
    int                  bus_start;
    logic                any_cs;

    adc_pio_poller #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .cmd_word       (cmd_word),
        .clear_ovf      (clear_ovf),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .overflow       (overflow),
        .fill_level     (fill_level),
        .state          (state)
    );

    // PIO responder: registers the input port on a read, one-cycle latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_chipselect && avm_write_n) avm_readdata <= {16'h0, in_port};
    end

    always @(negedge clk) begin
        if (avm_chipselect) bus_cnt <= bus_cnt + 1;
    end

    // Stream scoreboard: a transfer happens on the edge following a negedge
    // where valid && ready are both high.
    always @(negedge clk) begin
        if (!reset && sample_valid && sample_ready) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL stream_extra: observed %0h expected no sample", sample_data);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                assert (sample_data === mon_exp) else begin
                    miscompares++;
                    $error("FAIL stream_data: observed %0h expected %0h", sample_data, mon_exp);
                end
            end
        end
    end

    // driver tasks
    task automatic next(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_write(input string tag);
        int n;
        n = 0;
        while (!(avm_chipselect && !avm_write_n) && n < 3 * SAMPLE_DIV) begin
            next();
            n++;
        end
        vectors++;
        assert (avm_chipselect && !avm_write_n) else begin
            miscompares++;
            $error("FAIL %s_timeout: observed no write expected write within %0d cycles", tag, 3 * SAMPLE_DIV);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; cmd_word = '0; clear_ovf = 1'b0;
        sample_ready = 1'b0; in_port = '0;
        next(3);

        check("rst_cs",    32'(avm_chipselect), 32'd0);
        check("rst_wn",    32'(avm_write_n),    32'd1);
        check("rst_addr",  32'(avm_address),    32'd0);
        check("rst_wdata", avm_writedata,       32'd0);
        check("rst_sdata", 32'(sample_data),    32'd0);
        check("rst_valid", 32'(sample_valid),   32'd0);
        check("rst_ovf",   32'(overflow),       32'd0);
        check("rst_fill",  32'(fill_level),     32'd0);
        check("rst_state", 32'(state),          32'(IDLE));

        // first transaction: tick in cycle 8, WRITE 9, READ 10, valid 12
        reset = 1'b0; enable = 1'b1; cmd_word = 16'h0003; in_port = 16'h1234;
        any_cs = 1'b0;
        for (int i = 0; i < 7; i++) begin
            next();
            any_cs = any_cs | avm_chipselect;
        end
        check("pre_tick_idle", 32'(any_cs), 32'd0);
        next();
        check("wr_cs",    32'(avm_chipselect), 32'd1);
        check("wr_wn",    32'(avm_write_n),    32'd0);
        check("wr_wdata", avm_writedata,       32'h0000_0003);
        check("wr_state", 32'(state),          32'(WRITE));
        last_wr = cyc;
        exp_q.push_back(16'h1234);
        next();
        check("rd_cs",    32'(avm_chipselect), 32'd1);
        check("rd_wn",    32'(avm_write_n),    32'd1);
        check("rd_addr",  32'(avm_address),    32'd0);
        check("rd_wdata", avm_writedata,       32'd0);
        next();
        check("cap_state", 32'(state),          32'(CAPTURE));
        check("cap_cs",    32'(avm_chipselect), 32'd0);
        check("cap_valid", 32'(sample_valid),   32'd0);
        next();
        check("first_valid", 32'(sample_valid), 32'd1);
        check("first_data",  32'(sample_data),  32'h1234);
        check("first_fill",  32'(fill_level),   32'd1);
        sample_ready = 1'b1;

        // ramp, consumer always ready
        cmd_word = 16'h0005;
        for (int p = 0; p < 6; p++) begin
            wait_write("ramp");
            check("ramp_period", 32'(cyc - last_wr), 32'(SAMPLE_DIV));
            check("ramp_wdata",  avm_writedata,      32'h0000_0005);
            last_wr = cyc;
            in_port = 16'h2000 + 16'(p);
            exp_q.push_back(in_port);
            next(3);
        end
        next(2);
        check("ramp_drained", 32'(exp_q.size()), 32'd0);
        check("ramp_ovf",     32'(overflow),      32'd0);
        check("ramp_fill",    32'(fill_level),    32'd0);

        // consumer stalled for 20 periods; drop at period 18 overlaps clear_ovf
        sample_ready = 1'b0;
        for (int p = 0; p < 20; p++) begin
            wait_write("fill");
            in_port = 16'h3000 + 16'(p);
            if (p < FIFO_DEPTH) exp_q.push_back(in_port);
            if (p == 18) begin
                next(2);
                clear_ovf = 1'b1;
                next();
                clear_ovf = 1'b0;
            end else begin
                next(3);
            end
            check("fill_level", 32'(fill_level), (p < FIFO_DEPTH) ? 32'(p + 1) : 32'(FIFO_DEPTH));
            check("fill_ovf",   32'(overflow),   (p >= FIFO_DEPTH) ? 32'd1 : 32'd0);
        end
        check("full_head", 32'(sample_data), 32'h3000);
        clear_ovf = 1'b1;
        next();
        clear_ovf = 1'b0;
        check("clear_ovf", 32'(overflow), 32'd0);

        // full FIFO with a pop in the CAPTURE cycle
        wait_write("fullpop");
        in_port = 16'h4000;
        exp_q.push_back(in_port);
        next(2);
        sample_ready = 1'b1;
        next();
        sample_ready = 1'b0;
        check("fullpop_fill", 32'(fill_level), 32'(FIFO_DEPTH));
        check("fullpop_ovf",  32'(overflow),   32'd0);

        // drain with polling stopped
        enable = 1'b0;
        sample_ready = 1'b1;
        next(20);
        check("drain_q",     32'(exp_q.size()),  32'd0);
        check("drain_fill",  32'(fill_level),    32'd0);
        check("drain_valid", 32'(sample_valid),  32'd0);

        // enable dropped during READ
        enable = 1'b1;
        wait_write("endrop");
        in_port = 16'h5000;
        exp_q.push_back(in_port);
        next();
        check("endrop_read", 32'(state), 32'(READ));
        enable = 1'b0;
        next();
        check("endrop_capture", 32'(state), 32'(CAPTURE));
        next();
        check("endrop_valid", 32'(sample_valid), 32'd1);
        bus_start = bus_cnt;
        next(3 * SAMPLE_DIV + 2);
        check("endrop_quiet", 32'(bus_cnt - bus_start), 32'd0);
        check("endrop_q",     32'(exp_q.size()),        32'd0);
        check("endrop_idle",  32'(state),               32'(IDLE));

        // reset during WRITE
        sample_ready = 1'b0;
        enable = 1'b1;
        wait_write("rst_a");
        in_port = 16'h6000;
        next(3);
        wait_write("rst_b");
        check("prerst_fill", 32'(fill_level), 32'd1);
        reset = 1'b1;
        next();
        check("midrst_cs",    32'(avm_chipselect), 32'd0);
        check("midrst_wn",    32'(avm_write_n),    32'd1);
        check("midrst_wdata", avm_writedata,       32'd0);
        check("midrst_state", 32'(state),          32'(IDLE));
        check("midrst_fill",  32'(fill_level),     32'd0);
        check("midrst_valid", 32'(sample_valid),   32'd0);
        check("midrst_ovf",   32'(overflow),       32'd0);
        reset = 1'b0;
        enable = 1'b0;
        next(2);
        check("post_rst_cs", 32'(avm_chipselect), 32'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_pio_poller.md
# adc_pio_poller

Avalon-MM initiator that drives the ADC PIO responder at a fixed sample rate, without CPU involvement. Every sample period it writes a command word to the PIO output register (address 0), then reads the 16-bit ADC input at address 0. Captured samples go into a small FIFO and leave on a valid/ready stream toward the visualizer datapath. It sits between the ADC PIO slave port and the spectrum/visualizer pipeline, in the same clock domain as the Nios system.

## Interface
Parameters:
- SAMPLE_DIV, 1024: clock cycles per sample period; legal range ≥ 4.
- FIFO_DEPTH, 16: sample FIFO entries; power of two, ≥ 2.
- DATA_W, 16: sample width; equals the PIO in/out width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run polling while high.
- cmd_word  in  16  value written to PIO address 0 each period (ADC channel/control).
- clear_ovf  in  1  one-cycle pulse that clears overflow.
- avm_address  out  2  always 0 while active.
- avm_chipselect  out  1  bus access strobe.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  32  {16'b0, cmd_word}.
- avm_readdata  in  32  responder data; fixed one-cycle read latency, no waitrequest.
- sample_data  out  DATA_W  FIFO head.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts head when valid and ready are both high.
- overflow  out  1  sticky; a sample was dropped.
- fill_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Divider: counts 0..SAMPLE_DIV-1 while enable=1 and asserts a one-cycle tick at SAMPLE_DIV-1. Held at 0 while enable=0.
- FSM states and transitions:
  - IDLE → WRITE on tick.
  - WRITE: chipselect=1, write_n=0, writedata={16'b0,cmd_word}.
  - WRITE → READ: chipselect=1, write_n=1, address=0.
  - READ → CAPTURE: latch avm_readdata[DATA_W-1:0] and push it into the FIFO.
  - CAPTURE → IDLE.
- cmd_word is sampled in the WRITE cycle only.
- Outside WRITE/READ: chipselect=0, write_n=1, address=0, writedata=0.
- A tick that arrives while the FSM is not in IDLE cannot occur, because SAMPLE_DIV ≥ 4.
- enable falling mid-sequence: the current WRITE/READ/CAPTURE sequence completes, then the FSM stays in IDLE. The divider restarts from 0 when enable returns.
- FIFO full on push with no pop in the same cycle: the sample is discarded and overflow is set to 1.
- FIFO full with a simultaneous pop: the push is accepted and overflow is unchanged.
- clear_ovf in the same cycle as a new drop: overflow stays 1 (set wins).
- Pop when empty: ignored. Push and pop in the same cycle: fill_level unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, sample_data=0, sample_valid=0, overflow=0, fill_level=0. FSM=IDLE, divider=0, FIFO empty.
- First tick occurs SAMPLE_DIV cycles after enable rises, measured from the first clk edge with enable=1. Ticks then repeat every SAMPLE_DIV cycles.
- Tick at cycle T:
  - WRITE at T+1.
  - READ at T+2.
  - responder registers readdata at the edge ending T+2.
  - CAPTURE at T+3.
  - sample_valid visible at T+4 (FIFO registered output, first-word latency 1).
- Sample pushed in CAPTURE at T+3: fill_level increments at T+4.
- Reset asserted mid-sequence aborts in the next cycle. Bus outputs return to idle values with no partial write.

## Structure
- Shared package `adc_poller_pkg`:
  - FSM state enum (IDLE, WRITE, READ, CAPTURE).
  - DATA_W default.
  - PIO register address constant ADDR_DATA=0.
- One sub-module: `sync_fifo` (parameterized width/depth, registered output, full/empty/level). The top-level holds the divider, FSM and overflow flag.

## Test plan
- Reset then enable=1, SAMPLE_DIV=8, cmd_word=16'h0003, responder in_port=16'h1234:
  - WRITE pulse with writedata=32'h0000_0003 at cycle 9.
  - READ at cycle 10.
  - sample_data=16'h1234 with sample_valid=1 at cycle 12.
- in_port ramps +1 per period, sample_ready=1: stream outputs consecutive values, one per 8 cycles, and overflow stays 0.
- sample_ready=0 for 20 periods, FIFO_DEPTH=16:
  - fill_level saturates at 16.
  - overflow=1 after the 17th capture.
  - FIFO holds the first 16 values.
  - a clear_ovf pulse returns overflow to 0.
- FIFO full, sample_ready=1 asserted in the same cycle as CAPTURE: push is accepted, fill_level stays 16, overflow stays 0.
- enable dropped during READ: CAPTURE still pushes the sample, then no further bus activity for ≥ 3×SAMPLE_DIV cycles.
- reset pulsed during WRITE: chipselect=0 and write_n=1 on the next cycle, FIFO empty, overflow=0.
